// File: rtl/periph_arb_pkg.sv
// Shared types and the rotating-priority search used by the peripheral arbiter.
package periph_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int RR_MAX_REQ = 32;

    // Index of the first set bit of req scanning ptr, ptr+1, ... modulo n (n a power of two).
    function automatic int rr_find_first(input logic [RR_MAX_REQ-1:0] req,
                                         input int n,
                                         input int ptr);
        int idx;
        int found;
        found = 0;
        for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = (ptr + i) & (n - 1);
                if (req[idx[4:0]]) begin
                    found = idx;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/periph_arb_idx_fifo.sv
// Synchronous FIFO holding the master index of every granted, not yet answered transfer.
module periph_arb_idx_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/periph_rr_arb_ctrl.sv
// Round-robin owner selection for the shared peripheral port, with an outstanding-limit
// and in-order routing of responses back to the originating master.
module periph_rr_arb_ctrl
    import periph_arb_pkg::*;
#(
    parameter int N_MASTER        = 4,
    parameter int LOG_MASTER      = $clog2(N_MASTER),
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_MASTER-1:0]   req_i,
    output logic [N_MASTER-1:0]   gnt_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic [LOG_MASTER-1:0] sel_o,
    output logic [LOG_MASTER-1:0] rr_flag_o,
    input  logic                  r_valid_i,
    output logic [N_MASTER-1:0]   r_valid_o,
    output logic                  err_o,
    output arb_state_e            dbg_state_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Handshake: a transfer completes in the cycle req_o && gnt_i, and gnt_o pulses for
    // that cycle only; masters hold req_i until granted; r_valid_i has no back-pressure.
    arb_state_e            state_q, state_d;
    logic [LOG_MASTER-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_MASTER-1:0] lock_idx_q, lock_idx_d;
    logic                  err_q, err_d;
    logic [LOG_MASTER-1:0] winner;
    logic                  blocked;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [LOG_MASTER-1:0] fifo_head;
    logic [LOG_MASTER-1:0] push_idx;

    periph_arb_idx_fifo #(
        .WIDTH (LOG_MASTER),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_idx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (push_idx),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    // Blocking uses the registered count, so a same-cycle pop only frees a slot next cycle.
    assign blocked     = (fifo_count == CNT_W'(MAX_OUTSTANDING));
    assign winner      = LOG_MASTER'(rr_find_first(32'(req_i), N_MASTER, int'(rr_ptr_q)));
    assign rr_flag_o   = rr_ptr_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q;
        gnt_o      = '0;
        req_o      = 1'b0;
        sel_o      = '0;
        fifo_push  = 1'b0;
        push_idx   = winner;
        r_valid_o  = '0;
        fifo_pop   = 1'b0;

        if (blocked) begin
            if (state_q == ARB_LOCKED) begin
                sel_o = lock_idx_q;
            end
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|req_i) begin
                        req_o = 1'b1;
                        sel_o = winner;
                        if (gnt_i && !fifo_full) begin
                            gnt_o     = N_MASTER'(1) << winner;
                            fifo_push = 1'b1;
                            rr_ptr_d  = winner + LOG_MASTER'(1);
                        end else begin
                            lock_idx_d = winner;
                            state_d    = ARB_LOCKED;
                        end
                    end
                end
                ARB_LOCKED: begin
                    sel_o    = lock_idx_q;
                    req_o    = req_i[lock_idx_q];
                    push_idx = lock_idx_q;
                    if (!req_i[lock_idx_q]) begin
                        err_d   = 1'b1;
                        state_d = ARB_IDLE;
                    end else if (gnt_i && !fifo_full) begin
                        gnt_o     = N_MASTER'(1) << lock_idx_q;
                        fifo_push = 1'b1;
                        rr_ptr_d  = lock_idx_q + LOG_MASTER'(1);
                        state_d   = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end

        if (r_valid_i) begin
            if (fifo_empty) begin
                err_d = 1'b1;
            end else begin
                fifo_pop  = 1'b1;
                r_valid_o = N_MASTER'(1) << fifo_head;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_periph_rr_arb_ctrl.sv
// Directed bench for periph_rr_arb_ctrl: table of per-cycle vectors plus corner-case sequences.
module tb_periph_rr_arb_ctrl;
    import periph_arb_pkg::*;

    localparam int N   = 4;
    localparam int LOG = 2;
    localparam int MAXO = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic           gnt_i = 1'b0;
    logic           r_valid_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic           req_o;
    logic [LOG-1:0] sel_o;
    logic [LOG-1:0] rr_flag_o;
    logic [N-1:0]   r_valid_o;
    logic           err_o;
    arb_state_e     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0]   req;
        logic           gnt;
        logic           rv;
        logic [N-1:0]   e_gnt;
        logic           e_req;
        logic [LOG-1:0] e_sel;
        logic [LOG-1:0] e_rr;
        logic [N-1:0]   e_rvo;
        logic           e_err;
    } vec_t;

    vec_t tbl[12];

    periph_rr_arb_ctrl #(
        .N_MASTER        (N),
        .LOG_MASTER      (LOG),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .sel_o       (sel_o),
        .rr_flag_o   (rr_flag_o),
        .r_valid_i   (r_valid_i),
        .r_valid_o   (r_valid_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [N-1:0] req, input logic g, input logic rv,
                                input logic [N-1:0] egnt, input logic ereq,
                                input logic [LOG-1:0] esel, input logic [LOG-1:0] err_rr,
                                input logic [N-1:0] ervo, input logic eerr);
        vec_t v;
        v.req = req; v.gnt = g; v.rv = rv;
        v.e_gnt = egnt; v.e_req = ereq; v.e_sel = esel;
        v.e_rr = err_rr; v.e_rvo = ervo; v.e_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after posedge, compare at negedge, step to next cycle.
    task automatic run_vec(input vec_t v, input string tag);
        req_i = v.req;
        gnt_i = v.gnt;
        r_valid_i = v.rv;
        @(negedge clk);
        check({tag, " gnt_o"},     32'(gnt_o),     32'(v.e_gnt));
        check({tag, " req_o"},     32'(req_o),     32'(v.e_req));
        check({tag, " sel_o"},     32'(sel_o),     32'(v.e_sel));
        check({tag, " rr_flag_o"}, 32'(rr_flag_o), 32'(v.e_rr));
        check({tag, " r_valid_o"}, 32'(r_valid_o), 32'(v.e_rvo));
        check({tag, " err_o"},     32'(err_o),     32'(v.e_err));
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt_o"},     32'(gnt_o),     32'd0);
        check({tag, " req_o"},     32'(req_o),     32'd0);
        check({tag, " sel_o"},     32'(sel_o),     32'd0);
        check({tag, " rr_flag_o"}, 32'(rr_flag_o), 32'd0);
        check({tag, " r_valid_o"}, 32'(r_valid_o), 32'd0);
        check({tag, " err_o"},     32'(err_o),     32'd0);
        check({tag, " state"},     32'(dbg_state), 32'(ARB_IDLE));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req_i = '0;
        gnt_i = 1'b0;
        r_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        // Rotation with pulsed responses, then a stalled lock on master 1.
        tbl[0]  = mk(4'b1111, 1, 0, 4'b0001, 1, 0, 0, 4'b0000, 0);
        tbl[1]  = mk(4'b1111, 1, 1, 4'b0010, 1, 1, 1, 4'b0001, 0);
        tbl[2]  = mk(4'b1111, 1, 1, 4'b0100, 1, 2, 2, 4'b0010, 0);
        tbl[3]  = mk(4'b1111, 1, 1, 4'b1000, 1, 3, 3, 4'b0100, 0);
        tbl[4]  = mk(4'b1111, 1, 1, 4'b0001, 1, 0, 0, 4'b1000, 0);
        tbl[5]  = mk(4'b0000, 0, 1, 4'b0000, 0, 0, 1, 4'b0001, 0);
        tbl[6]  = mk(4'b0110, 0, 0, 4'b0000, 1, 1, 1, 4'b0000, 0);
        tbl[7]  = mk(4'b0010, 0, 0, 4'b0000, 1, 1, 1, 4'b0000, 0);
        tbl[8]  = mk(4'b0110, 0, 0, 4'b0000, 1, 1, 1, 4'b0000, 0);
        tbl[9]  = mk(4'b0110, 1, 0, 4'b0010, 1, 1, 1, 4'b0000, 0);
        tbl[10] = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 2, 4'b0000, 0);
        tbl[11] = mk(4'b0000, 0, 1, 4'b0000, 0, 0, 2, 4'b0010, 0);

        do_reset("reset0");
        for (int i = 0; i < 12; i++) begin
            run_vec(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Outstanding limit: four grants fill the FIFO, then the port is blocked.
        do_reset("reset1");
        for (int k = 0; k < 4; k++) begin
            run_vec(mk(4'b1111, 1, 0, 4'(1 << k), 1, 2'(k), 2'(k), 4'b0000, 0),
                    $sformatf("fill%0d", k));
        end
        run_vec(mk(4'b1111, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0), "blocked");
        run_vec(mk(4'b1111, 1, 1, 4'b0000, 0, 0, 0, 4'b0001, 0), "blocked_pop");
        run_vec(mk(4'b1111, 1, 0, 4'b0001, 1, 0, 0, 4'b0000, 0), "unblocked");

        // Responses return in grant order: masters 3, 1, 2.
        do_reset("reset2");
        run_vec(mk(4'b1000, 1, 0, 4'b1000, 1, 3, 0, 4'b0000, 0), "grant3");
        exp_q.push_back(4'b1000);
        run_vec(mk(4'b0010, 1, 0, 4'b0010, 1, 1, 0, 4'b0000, 0), "grant1");
        exp_q.push_back(4'b0010);
        run_vec(mk(4'b0100, 1, 0, 4'b0100, 1, 2, 2, 4'b0000, 0), "grant2");
        exp_q.push_back(4'b0100);
        for (int k = 0; k < 3; k++) begin
            logic [N-1:0] e;
            e = exp_q.pop_front();
            run_vec(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 3, e, 0), $sformatf("resp%0d", k));
        end

        // Locked master drops its request: no grant, sticky error.
        do_reset("reset3");
        run_vec(mk(4'b0100, 0, 0, 4'b0000, 1, 2, 0, 4'b0000, 0), "lock2");
        run_vec(mk(4'b0000, 0, 0, 4'b0000, 0, 2, 0, 4'b0000, 0), "drop2");
        check("drop2 state", 32'(dbg_state), 32'(ARB_IDLE));
        run_vec(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1), "err_set");
        run_vec(mk(4'b1111, 1, 0, 4'b0001, 1, 0, 0, 4'b0000, 1), "err_sticky");

        // Response with an empty FIFO is dropped and flags an error.
        do_reset("reset4");
        run_vec(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 4'b0000, 0), "empty_resp");
        run_vec(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1), "empty_err");

        // Asynchronous reset while LOCKED with two entries queued.
        do_reset("reset5");
        run_vec(mk(4'b1111, 1, 0, 4'b0001, 1, 0, 0, 4'b0000, 0), "pre_q0");
        run_vec(mk(4'b1111, 1, 0, 4'b0010, 1, 1, 1, 4'b0000, 0), "pre_q1");
        run_vec(mk(4'b1111, 0, 0, 4'b0000, 1, 2, 2, 4'b0000, 0), "pre_lock");
        check("pre_rst state", 32'(dbg_state), 32'(ARB_LOCKED));
        req_i = '0;
        #2;
        check("pre_rst sel_o", 32'(sel_o), 32'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(mk(4'b1111, 1, 1, 4'b0001, 1, 0, 0, 4'b0000, 0), "post_rst");
        run_vec(mk(4'b0000, 0, 0, 4'b0000, 0, 0, 1, 4'b0000, 1), "post_rst_err");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_rr_arb_ctrl.md
# periph_rr_arb_ctrl

Round-robin arbitration controller for the peripheral interconnect request tree. It sits beside the 2-to-1 fan-in mux tree and decides which of N_MASTER requesters owns the shared peripheral port. It drives the tree's round-robin flags and the winner index, holds the selection stable while the slave stalls, and limits outstanding transactions. It also routes each response back to its originating master, in order, through an internal index FIFO.

## Interface
- N_MASTER, 4: number of requesters; power of two, ≥2.
- LOG_MASTER, $clog2(N_MASTER): width of index and RR flag.
- MAX_OUTSTANDING, 4: response FIFO depth; ≥1.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  N_MASTER  per-master request; a master holds it high until granted.
- gnt_o  out  N_MASTER  per-master grant, one-hot or zero.
- req_o  out  1  request to peripheral slave.
- gnt_i  in  1  slave grant (GNT-based flow control).
- sel_o  out  LOG_MASTER  winner index; drives the datapath mux select.
- rr_flag_o  out  LOG_MASTER  round-robin pointer; bit k feeds RR_FLAG of tree level k.
- r_valid_i  in  1  slave response valid, in request order.
- r_valid_o  out  N_MASTER  per-master response valid, one-hot or zero.
- err_o  out  1  sticky protocol-error flag.

## Operation
- State machine, two states:
  - IDLE: no selection held.
  - LOCKED: winner held while the slave stalls.
- Pointer rr_ptr resets to 0 and drives rr_flag_o directly.
- Blocking: the block is blocked when the registered FIFO count equals MAX_OUTSTANDING. When blocked, req_o=0 and gnt_o=0, and the FSM stays in its current state.
- IDLE, not blocked, any req_i set:
  - Winner is the first set bit of req_i scanning rr_ptr, rr_ptr+1, … modulo N_MASTER.
  - Drive req_o=1 and sel_o=winner.
  - gnt_i=1: gnt_o[winner]=1; rr_ptr←winner+1 mod N; push winner into the FIFO; stay in IDLE.
  - gnt_i=0: latch winner into lock_idx and go to LOCKED.
- LOCKED:
  - Drive sel_o=lock_idx and req_o=req_i[lock_idx]; other requests are ignored.
  - On gnt_i=1: grant, push, and advance the pointer as in IDLE, then go to IDLE.
  - If req_i[lock_idx] drops before grant: set err_o, return to IDLE, no grant.
- Responses:
  - r_valid_i=1 with FIFO non-empty: pop the head and set r_valid_o[head]=1.
  - r_valid_i=1 with FIFO empty: ignored; set err_o.
- Simultaneous push and pop: count unchanged, order preserved.
- A pop in the cycle the block is blocked does not unblock it until the next cycle, because the count is registered.
- err_o clears only on reset.

## Timing
- Reset values: gnt_o=0, req_o=0, sel_o=0, rr_flag_o=0, r_valid_o=0, err_o=0. FSM=IDLE, FIFO empty, lock_idx=0.
- gnt_o is combinational from gnt_i: zero latency; a transfer completes in the cycle where req_o & gnt_i.
- r_valid_o is combinational from r_valid_i and the FIFO head: zero latency.
- req_o and sel_o are combinational from req_i and registered state; there is no request-path register.
- rr_ptr, the FIFO and the count update on the clock edge following the grant or response.
- Reset asserted mid-transaction: all state clears immediately. In-flight responses are discarded, and masters must re-issue.

## Structure
- Package periph_arb_pkg holds:
  - state enum arb_state_e {ARB_IDLE, ARB_LOCKED};
  - the rotating-priority find-first function.
- Sub-module periph_arb_idx_fifo is a LOG_MASTER-wide, MAX_OUTSTANDING-deep synchronous FIFO. It has push/pop ports and outputs full, empty, count and head. It uses the same clk and rst_n.
- The top level holds the FSM, rr_ptr, lock_idx, err_o and output decode.

## Test plan
- All 4 req_i high, gnt_i tied 1, r_valid_i pulsed each cycle → grants rotate to masters 0,1,2,3,0; rr_flag_o steps 0→1→2→3→0.
- req_i=0b0110 with gnt_i=0 for 3 cycles then 1 → sel_o=1 throughout, even if req_i[2] toggles; gnt_o=0b0010 on cycle 4; rr_flag_o becomes 2.
- MAX_OUTSTANDING=4, gnt_i=1, no responses → 4 grants, then req_o=0. One r_valid_i pulse → req_o reasserts the following cycle.
- Grants to masters 3, 1, 2, then three r_valid_i pulses → r_valid_o = 0b1000, 0b0010, 0b0100 in order.
- Locked master 2 drops req before gnt_i → no grant, err_o=1 and stays high; r_valid_i with empty FIFO also sets err_o.
- rst_n pulsed low while LOCKED with 2 entries queued → all outputs 0 asynchronously; after release, the first grant goes to master 0 and the FIFO is empty.
